// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings and the multiplier controller state type.
package alu_pkg;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   localparam int MULT_N = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
endpackage

// File: rtl/alu_shift_add_mult_if.sv
// Start/busy/done handshake and operand/product bus of the shift-add multiplier.
interface alu_shift_add_mult_if #(parameter int N = 8);
   logic           start;
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
   logic [2*N-1:0] product;
   logic           busy;
   logic           done;

   modport master (output start, multiplicand, multiplier, input product, busy, done);
   modport slave  (input start, multiplicand, multiplier, output product, busy, done);
endinterface

// File: rtl/alu_shift_add_mult.sv
// Sequential unsigned NxN multiplier: one shift-and-add step per clock through the
// external combinational ALU's ADD path, product formed in {acc,q}.
module alu_shift_add_mult
   import alu_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_shift_add_mult_if.slave  bus,
   output logic [N-1:0]         alu_a,
   output logic [N-1:0]         alu_b,
   output logic [1:0]           alu_control,
   input  logic [N-1:0]         alu_result,
   input  logic                 alu_c
);
   localparam int CNT_W = $clog2(N);

   mult_state_t      state, state_nxt;
   logic [N-1:0]     m, m_nxt;
   logic [N-1:0]     acc, acc_nxt;
   logic [N-1:0]     q, q_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         m     <= '0;
         acc   <= '0;
         q     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         m     <= m_nxt;
         acc   <= acc_nxt;
         q     <= q_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      m_nxt       = m;
      acc_nxt     = acc;
      q_nxt       = q;
      cnt_nxt     = cnt;
      alu_a       = acc;
      alu_b       = m;
      alu_control = ALU_ADD;
      bus.busy    = 1'b0;
      bus.done    = 1'b0;
      bus.product = {acc, q};

      unique case (state)
         IDLE: begin
            if (bus.start) begin
               m_nxt     = bus.multiplicand;
               q_nxt     = bus.multiplier;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            bus.busy = 1'b1;
            // Carry-out becomes the new accumulator MSB, so the 2N-bit result never overflows.
            if (q[0]) {acc_nxt, q_nxt} = {alu_c, alu_result, q[N-1:1]};
            else      {acc_nxt, q_nxt} = {1'b0, acc, q[N-1:1]};
            cnt_nxt = cnt + 1'b1;
            if (cnt == CNT_W'(N-1)) state_nxt = DONE;
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_alu_shift_add_mult.sv
// Directed bench for alu_shift_add_mult with a behavioural model of the attached ALU.
module tb_alu_shift_add_mult;
   import alu_pkg::*;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] alu_a, alu_b, alu_result;
   logic [1:0]   alu_control;
   logic         alu_c;

   int errs   = 0;
   int checks = 0;

   alu_shift_add_mult_if #(.N(N)) bus ();

   alu_shift_add_mult #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .alu_c       (alu_c)
   );

   always #5 clk = ~clk;

   // Lab ALU: purely combinational, carry is the 9th bit of ADD.
   always_comb begin
      alu_c      = 1'b0;
      alu_result = '0;
      case (alu_control)
         ALU_ADD: {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_AND: alu_result = alu_a & alu_b;
         default: alu_result = alu_a | alu_b;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one multiply and watch 12 cycles after acceptance. Optionally re-raise
   // start with other operands during RUN cycle inj_cyc (must be dropped).
   task automatic do_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int inj_cyc,
                         input logic [7:0] ia, input logic [7:0] ib);
      int bc, dc, dn, both;
      logic [15:0] p;
      bc = 0; dc = 0; dn = 0; both = 0; p = '0;
      bus.start = 1'b1; bus.multiplicand = a; bus.multiplier = b;
      step();
      bus.start = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         if (bus.busy) bc++;
         if (bus.busy && bus.done) both++;
         if (bus.done) begin
            dn++;
            if (dc == 0) dc = i;
            p = bus.product;
         end
         if (i == inj_cyc) begin
            bus.start = 1'b1; bus.multiplicand = ia; bus.multiplier = ib;
         end else begin
            bus.start = 1'b0;
         end
         step();
      end
      chk({tag, " busy_cycles"}, bc, 8);
      chk({tag, " done_cycle"}, dc, 9);
      chk({tag, " done_pulses"}, dn, 1);
      chk({tag, " busy_and_done"}, both, 0);
      chk({tag, " product"}, p, exp);
   endtask

   initial begin
      int dn, d1, d2;
      logic [15:0] p1, p2;
      reset = 1'b1;
      bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
      step(); step();
      chk("rst product", bus.product, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst alu_a", alu_a, 0);
      chk("rst alu_b", alu_b, 0);
      chk("rst alu_control", alu_control, 0);

      // Reset together with start: reset wins.
      bus.start = 1'b1; bus.multiplicand = 8'd7; bus.multiplier = 8'd7;
      step();
      bus.start = 1'b0; reset = 1'b0;
      step();
      chk("rst+start busy", bus.busy, 0);
      chk("rst+start alu_b", alu_b, 0);

      do_mul("13x11", 8'd13, 8'd11, 16'h008F, 0, 8'd0, 8'd0);
      do_mul("255x255", 8'd255, 8'd255, 16'hFE01, 0, 8'd0, 8'd0);
      do_mul("0x200", 8'd0, 8'd200, 16'h0000, 0, 8'd0, 8'd0);
      do_mul("1x173", 8'd1, 8'd173, 16'h00AD, 0, 8'd0, 8'd0);
      do_mul("6x7 busy_start", 8'd6, 8'd7, 16'h002A, 3, 8'd9, 8'd9);

      // Reset in RUN cycle 4 abandons the operation.
      bus.start = 1'b1; bus.multiplicand = 8'd100; bus.multiplier = 8'd3;
      step();
      bus.start = 1'b0;
      step(); step(); step();
      chk("midrst busy_before", bus.busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst busy", bus.busy, 0);
      chk("midrst done", bus.done, 0);
      chk("midrst product", bus.product, 0);
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done || bus.busy) dn++;
         step();
      end
      chk("midrst no_activity", dn, 0);
      do_mul("5x5", 8'd5, 8'd5, 16'h0019, 0, 8'd0, 8'd0);

      // Back-to-back with start held high.
      d1 = 0; d2 = 0; p1 = '0; p2 = '0;
      bus.start = 1'b1; bus.multiplicand = 8'd12; bus.multiplier = 8'd12;
      step();
      bus.multiplicand = 8'd15; bus.multiplier = 8'd15;
      for (int i = 1; i <= 25; i++) begin
         if (bus.done) begin
            if (d1 == 0) begin
               d1 = i; p1 = bus.product;
            end else if (d2 == 0) begin
               d2 = i; p2 = bus.product;
               bus.start = 1'b0;
            end
         end
         step();
      end
      bus.start = 1'b0;
      chk("b2b first_done", d1, 9);
      chk("b2b done_spacing", d2 - d1, 10);
      chk("b2b product1", p1, 16'h0090);
      chk("b2b product2", p2, 16'h00E1);
      step(); step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/alu_shift_add_mult.md
# alu_shift_add_mult

Sequential unsigned N×N multiplier controller that time-shares the lab ALU's ADD path to form a 2N-bit product by shift-and-add. It owns the operand/accumulator registers and sequencing FSM and drives the ALU's A/B/ALUControl inputs. It consumes the ALU's Result and C outputs and presents a start/busy/done handshake to the surrounding lab top level. One partial-product step completes per clock; the ALU stays purely combinational.

## Interface
- N, 8, operand width; must equal the attached ALU width (only 8 is supported)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- multiplicand  input  N  unsigned operand M, captured on accepted start
- multiplier  input  N  unsigned operand Q, captured on accepted start
- alu_a  output  N  ALU A input (accumulator)
- alu_b  output  N  ALU B input (latched multiplicand)
- alu_control  output  2  ALU op select; constant 2'b00 (ADD)
- alu_result  input  N  ALU Result
- alu_c  input  1  ALU carry-out flag
- product  output  2N  result; valid while done=1 and held until next accepted start
- busy  output  1  high from the cycle after an accepted start through the last RUN cycle
- done  output  1  one-cycle pulse when product becomes valid

## Operation
- Registers: m[N-1:0], acc[N-1:0], q[N-1:0], cnt[$clog2(N)-1:0], state.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0. If start=1: m<=multiplicand, q<=multiplier, acc<=0, cnt<=0, go to RUN. Otherwise hold all registers.
- RUN: busy=1. alu_a=acc, alu_b=m, alu_control=ADD.
  - If q[0]=1: {acc,q} <= {alu_c, alu_result, q[N-1:1]}.
  - If q[0]=0: {acc,q} <= {1'b0, acc, q[N-1:1]}.
  - Each RUN cycle: cnt<=cnt+1. When cnt==N-1, go to DONE.
- DONE: done=1, busy=0. Go to IDLE unconditionally. A start seen in DONE is ignored.
- product={acc,q}, continuously. It is meaningful only from DONE until the next accepted start.
- start while busy (RUN) is ignored; operands are not re-sampled.
- alu_a, alu_b and alu_control are driven in every state. In IDLE/DONE they carry acc/m/ADD, and the ALU outputs are ignored there.
- Arithmetic is unsigned. The ALU V/Neg/Z flags are unused. The carry is captured as the new MSB, so no overflow is possible.
- Reset (any state, including mid-RUN): state=IDLE, acc=0, q=0, m=0, cnt=0. Any in-flight operation is abandoned with no done pulse.

## Timing
- Reset values: product=0, busy=0, done=0, alu_a=0, alu_b=0, alu_control=2'b00.
- start accepted at edge k. busy=1 in cycles k+1…k+N. done=1 in cycle k+N+1 only. busy=0 in the done cycle.
- Latency from start to done is N+1 cycles (9 for N=8). Throughput is one multiply per N+2 cycles, since start is taken only in IDLE.
- The ALU path is combinational within one cycle: acc/m regs → ALU → acc/q regs.
- reset asserted together with start: reset wins, and the block stays in IDLE.

## Structure
- Shared package alu_pkg:
  - ALU op encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t.
- Single controller module with no sub-modules. The ALU is instantiated beside it in the integration wrapper alu_mult_top, which connects alu_* ports to ALU A/B/ALUControl/Result/C.
- Implementation: one always_ff for state/registers, one always_comb for next-state and outputs.

## Test plan
- Basic multiply: reset 2 cycles; multiplicand=13, multiplier=11, start 1 cycle. Required: busy for 8 cycles, done in cycle 9 after start, product=16'h008F.
- Carry path: 255×255. Required: product=16'hFE01, with alu_c=1 captured on carry iterations.
- Zero and identity: 0×200 → product=0; 1×173 → product=16'h00AD. Both with the same 9-cycle latency.
- Start ignored while busy: start 6×7, then reassert start with 9×9 in RUN cycle 3. Required: product=16'h002A, a single done pulse, and the second request dropped.
- Reset mid-operation: start 100×3, assert reset in RUN cycle 4. Required: next cycle busy=0, done=0, product=0, no done pulse afterward. A fresh 5×5 then gives 16'h0019.
- Back-to-back: start held high continuously with 12×12 then 15×15. Required: each operation takes N+2 cycles apart, products 16'h0090 then 16'h00E1, with done pulses exactly 10 cycles apart.
